// File: rtl/neopixel_gamma_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : neopixel_gamma_bridge_if
// Purpose  : Avalon-MM burst-read bundle. One instance carries the NEOPIXEL
//            request path into the bridge (slave modport), another carries
//            the bridge's request path out to SDRAM (master modport).
// Signals  : address          burst start address
//            read             read request
//            wait_request     stall; command taken when read && !wait_request
//            burst_count      words in burst
//            read_data        returned 32-bit word
//            read_data_valid  read_data qualifier
// Revision : 1.0 - initial release
// ============================================================================
interface neopixel_gamma_bridge_if #(
  parameter int pBURST_W = 5,
  parameter int pADDR_W  = 32
);
  logic [pADDR_W-1:0]  address;
  logic                read;
  logic                wait_request;
  logic [pBURST_W-1:0] burst_count;
  logic [31:0]         read_data;
  logic                read_data_valid;

  // Requester side: issues commands, receives data.
  modport master (
    output address, read, burst_count,
    input  wait_request, read_data, read_data_valid
  );

  // Responder side: accepts commands, returns data.
  modport slave (
    input  address, read, burst_count,
    output wait_request, read_data, read_data_valid
  );
endinterface
`default_nettype wire

// File: rtl/neopixel_gamma_bridge.sv
`default_nettype none
// ============================================================================
// Module   : neopixel_gamma_bridge
// Purpose  : Burst-read bridge between the NEOPIXEL data master and SDRAM.
//            Forwards each burst command upstream and transforms every
//            returned pixel word: per-byte gamma lookup (256x8 LUT) followed
//            by global brightness scaling, in a fixed 2-clock pipeline.
// Ports    : iCLOCK / iRESET     clock, synchronous active-high reset
//            s_if (slave)        command/return path from NEOPIXEL
//            m_if (master)       command/return path to memory
//            iCSR_ADDRESS        0 CTRL, 1 LUT_IDX, 2 LUT_DATA, 3 STATUS
//            iCSR_READ/WRITE     CSR strobes
//            iCSR_WRITE_DATA     CSR write data
//            oCSR_READ_DATA      registered CSR read data (1-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module neopixel_gamma_bridge #(
  parameter int pBURST_W = 5,
  parameter int pADDR_W  = 32
) (
  input  wire logic               iCLOCK,
  input  wire logic               iRESET,
  neopixel_gamma_bridge_if.slave  s_if,
  neopixel_gamma_bridge_if.master m_if,
  input  wire logic [1:0]         iCSR_ADDRESS,
  input  wire logic               iCSR_READ,
  input  wire logic               iCSR_WRITE,
  input  wire logic [31:0]        iCSR_WRITE_DATA,
  output logic      [31:0]        oCSR_READ_DATA
);

  localparam logic [1:0] CSR_CTRL     = 2'd0;
  localparam logic [1:0] CSR_LUT_IDX  = 2'd1;
  localparam logic [1:0] CSR_LUT_DATA = 2'd2;
  localparam logic [1:0] CSR_STATUS   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Command FSM
  // --------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [pADDR_W-1:0]  addr_q, addr_d;
  logic [pBURST_W-1:0] bcnt_q, bcnt_d;
  logic [pBURST_W-1:0] rem_q, rem_d;
  logic                s_wait;
  logic                m_read;
  logic                take;

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      bcnt_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    rem_d   = rem_q;
    s_wait  = 1'b1;
    m_read  = 1'b0;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_wait = 1'b0;
        if (s_if.read) begin
          addr_d  = s_if.address;
          bcnt_d  = s_if.burst_count;
          rem_d   = s_if.burst_count;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        m_read = 1'b1;
        if (!m_if.wait_request) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // Only words returned while a burst is outstanding enter the pipeline.
        take = m_if.read_data_valid;
        if (m_if.read_data_valid) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == pBURST_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_if.wait_request = s_wait;
  assign m_if.read         = m_read;
  assign m_if.address      = addr_q;
  assign m_if.burst_count  = bcnt_q;

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  logic       bypass_q;
  logic       passb3_q;
  logic [7:0] bright_q;
  logic [7:0] idx_q;
  logic       lut_we;

  assign lut_we = iCSR_WRITE && (iCSR_ADDRESS == CSR_LUT_DATA);

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      bypass_q <= 1'b1;
      passb3_q <= 1'b1;
      bright_q <= 8'hFF;
      idx_q    <= 8'd0;
    end else if (iCSR_WRITE) begin
      case (iCSR_ADDRESS)
        CSR_CTRL: begin
          bypass_q <= iCSR_WRITE_DATA[0];
          passb3_q <= iCSR_WRITE_DATA[1];
          bright_q <= iCSR_WRITE_DATA[15:8];
        end
        CSR_LUT_IDX:  idx_q <= iCSR_WRITE_DATA[7:0];
        // Auto-increment so a full table loads with one index write; wraps.
        CSR_LUT_DATA: idx_q <= idx_q + 8'd1;
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Gamma LUT: four identical copies so all four bytes of a word are looked
  // up in the same cycle. Every copy takes the same write.
  // --------------------------------------------------------------------------
  logic [3:0][7:0] raw;
  logic [3:0][7:0] lut_rd;
  logic [7:0]      lut_csr_rd;

  assign raw = m_if.read_data;

  for (genvar k = 0; k < 4; k++) begin : g_lut
    logic [7:0] mem_q [0:255];

    always_ff @(posedge iCLOCK) begin
      if (lut_we) begin
        mem_q[idx_q] <= iCSR_WRITE_DATA[7:0];
      end
    end

    assign lut_rd[k] = mem_q[raw[k]];

    if (k == 0) begin : g_csr_port
      assign lut_csr_rd = mem_q[idx_q];
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: gamma. Brightness and byte-3 mode are captured alongside the
  // word so a CSR write never affects a word already in flight.
  // --------------------------------------------------------------------------
  logic [3:0][7:0] s1_d;
  logic            s1_vld_q;
  logic [3:0][7:0] s1_data_q;
  logic [7:0]      s1_bright_q;
  logic            s1_passb3_q;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      s1_d[k] = bypass_q ? raw[k] : lut_rd[k];
    end
    if (passb3_q) begin
      s1_d[3] = raw[3];
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      s1_vld_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_bright_q <= 8'd0;
      s1_passb3_q <= 1'b0;
    end else begin
      s1_vld_q <= take;
      if (take) begin
        s1_data_q   <= s1_d;
        s1_bright_q <= bright_q;
        s1_passb3_q <= passb3_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: brightness. Scaling by (bright+1)/256 makes 255 an exact
  // identity and 0 force black.
  // --------------------------------------------------------------------------
  logic [8:0]      scale;
  logic [3:0][7:0] s2_d;
  logic            out_vld_q;
  logic [3:0][7:0] out_data_q;

  assign scale = {1'b0, s1_bright_q} + 9'd1;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      s2_d[k] = 8'(({9'd0, s1_data_q[k]} * {8'd0, scale}) >> 8);
    end
    // Byte 3 carries the APA102 frame header and must reach the LEDs intact.
    if (s1_passb3_q) begin
      s2_d[3] = s1_data_q[3];
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      out_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        out_data_q <= s2_d;
      end
    end
  end

  assign s_if.read_data_valid = out_vld_q;
  assign s_if.read_data       = out_data_q;

  // --------------------------------------------------------------------------
  // CSR read port
  // --------------------------------------------------------------------------
  logic busy;

  assign busy = (state_q != ST_IDLE) || s1_vld_q || out_vld_q;

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      oCSR_READ_DATA <= 32'd0;
    end else if (iCSR_READ) begin
      case (iCSR_ADDRESS)
        CSR_CTRL:     oCSR_READ_DATA <= {16'd0, bright_q, 6'd0, passb3_q, bypass_q};
        CSR_LUT_IDX:  oCSR_READ_DATA <= {24'd0, idx_q};
        CSR_LUT_DATA: oCSR_READ_DATA <= {24'd0, lut_csr_rd};
        CSR_STATUS:   oCSR_READ_DATA <= {30'd0, bypass_q, busy};
        default:      oCSR_READ_DATA <= 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire
